// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C master byte engine
//
// Purpose: grants one of N_REQ requesters exclusive use of the master engine,
// forwards the owner's commands, enforces START-first and releases the bus
// only after the engine reports STOP completion.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN (idle-ownership timeout that
// forces a STOP on behalf of a stalled owner).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req[N_REQ]              per-requester bus request (level)
//   cmd_valid[N_REQ]        per-requester command valid
//   cmd_flat[10*N_REQ]      per-requester {op[1:0], data[7:0]}
//   cmd_ready[N_REQ]        per-requester command accepted
//   grant[N_REQ]            registered one-hot owner
//   m_valid/m_op/m_data     command to master engine
//   m_ready                 master engine accepts command
//   m_done                  master finished STOP (pulse)
//   busy                    arbiter not idle
//   proto_err               pulse on a dropped (non-START first) command
//   abort                   pulse on ownership timeout
module i2c_arbiter #(
   parameter int          N_REQ          = 4,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     cmd_valid,
   input  logic [10*N_REQ-1:0]  cmd_flat,
   output logic [N_REQ-1:0]     cmd_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 m_valid,
   output logic [1:0]           m_op,
   output logic [7:0]           m_data,
   input  logic                 m_ready,
   input  logic                 m_done,
   output logic                 busy,
   output logic                 proto_err,
   output logic                 abort
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b11;

`ifdef I2C_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, OWNED, WAIT_DONE, RELEASE, FORCE_STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, OWNED, WAIT_DONE, RELEASE} state_t;
`endif

   state_t          state, state_nxt;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   last_owner;
   logic            started;      // a START has been accepted this ownership
   logic [IW-1:0]   winner;
   logic            any_req;
   logic [9:0]      cur_cmd;
   logic            cur_valid;
   logic            legal;
   logic            accept;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [15:0]     idle_cnt;
   logic            abort_c;
`endif

   // Round-robin search beginning just after the previous owner.
   always_comb begin
      logic [IW-1:0] cand;
      winner  = '0;
      any_req = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(last_owner) + k) % N_REQ);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   // Owner's command selected by the one-hot grant register.
   always_comb begin
      cur_cmd = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) cur_cmd = cmd_flat[10*i +: 10];
      end
   end

   assign cur_valid = |(cmd_valid & grant);
   assign legal     = started || (cur_cmd[9:8] == OP_START);

   always_comb begin
      state_nxt = state;
      cmd_ready = '0;
      m_valid   = 1'b0;
      m_op      = 2'b00;
      m_data    = 8'h00;
      proto_err = 1'b0;
      accept    = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      abort_c   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (any_req) state_nxt = OWNED;
         end
         OWNED: begin
            m_op      = cur_cmd[9:8];
            m_data    = cur_cmd[7:0];
            m_valid   = cur_valid && legal;
            // An illegal first command is swallowed without waiting on the engine.
            cmd_ready = grant & {N_REQ{legal ? m_ready : 1'b1}};
            accept    = cur_valid && (legal ? m_ready : 1'b1);
            proto_err = cur_valid && !legal;
            if (m_valid && m_ready && (m_op == OP_STOP)) begin
               state_nxt = WAIT_DONE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (!accept && (idle_cnt == TIMEOUT_CYCLES - 16'd1)) begin
               abort_c   = 1'b1;
               state_nxt = FORCE_STOP;
            end
`endif
         end
         WAIT_DONE: begin
            if (m_done) state_nxt = RELEASE;
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
`ifdef I2C_ARB_TIMEOUT_EN
         FORCE_STOP: begin
            m_valid = 1'b1;
            m_op    = OP_STOP;
            if (m_ready) state_nxt = WAIT_DONE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= '0;
         owner      <= '0;
         last_owner <= IW'(N_REQ - 1);
         started    <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && any_req) begin
            grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            owner   <= winner;
            started <= 1'b0;
         end
         if ((state == OWNED) && accept && legal && (cur_cmd[9:8] == OP_START)) begin
            started <= 1'b1;
         end
         if ((state == WAIT_DONE) && m_done) begin
            grant      <= '0;
            last_owner <= owner;
         end
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= 16'd0;
      end else if (state == OWNED) begin
         idle_cnt <= accept ? 16'd0 : idle_cnt + 16'd1;
      end else begin
         idle_cnt <= 16'd0;
      end
   end
   assign abort = abort_c;
`else
   assign abort = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [3:0]  cmd_valid;
   logic [39:0] cmd_flat;
   logic [3:0]  cmd_ready;
   logic [3:0]  grant;
   logic        m_valid;
   logic [1:0]  m_op;
   logic [7:0]  m_data;
   logic        m_ready;
   logic        m_done;
   logic        busy;
   logic        proto_err;
   logic        abort;

   int total = 0;
   int bad   = 0;

   i2c_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16'd10)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .cmd_valid (cmd_valid),
      .cmd_flat  (cmd_flat),
      .cmd_ready (cmd_ready),
      .grant     (grant),
      .m_valid   (m_valid),
      .m_op      (m_op),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .m_done    (m_done),
      .busy      (busy),
      .proto_err (proto_err),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic [1:0] op, input logic [7:0] d);
      cmd_flat[10*i +: 10] = {op, d};
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req       = '0;
      cmd_valid = '0;
      cmd_flat  = '0;
      m_ready   = 1'b0;
      m_done    = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req       = 4'b1111;
      cmd_valid = 4'b1111;
      cmd_flat  = '0;
      m_ready   = 1'b1;
      m_done    = 1'b0;
      tick();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      total++; if (cmd_ready !== 4'b0000) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0000", cmd_ready); end
      total++; if ({proto_err, abort} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {proto_err, abort}); end
   endtask

   task automatic test_basic();
      do_reset();
      req = 4'b0001;
      #1;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL basic_no_early_grant got=%b exp=0000", grant); end
      tick();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL basic_grant got=%b exp=0001", grant); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
      set_cmd(0, 2'b00, 8'h00); cmd_valid = 4'b0001; m_ready = 1'b1;
      #1;
      total++; if ({m_valid, m_op, cmd_ready} !== 7'b1_00_0001) begin bad++; $display("FAIL basic_start got=%b exp=1000001", {m_valid, m_op, cmd_ready}); end
      tick();
      set_cmd(0, 2'b01, 8'hA5);
      #1;
      total++; if ({m_valid, m_op, m_data} !== {1'b1, 2'b01, 8'hA5}) begin bad++; $display("FAIL basic_write got=%h exp=%h", {m_valid, m_op, m_data}, {1'b1, 2'b01, 8'hA5}); end
      tick();
      set_cmd(0, 2'b11, 8'h00);
      #1;
      total++; if ({m_valid, m_op} !== 3'b1_11) begin bad++; $display("FAIL basic_stop got=%b exp=111", {m_valid, m_op}); end
      tick();
      total++; if ({m_valid, cmd_ready} !== 5'b0_0000) begin bad++; $display("FAIL basic_wait_quiet got=%b exp=00000", {m_valid, cmd_ready}); end
      cmd_valid = '0;
      tick();
      total++; if ({grant, busy} !== 5'b0001_1) begin bad++; $display("FAIL basic_hold_wait got=%b exp=00011", {grant, busy}); end
      m_done = 1'b1;
      tick();
      m_done = 1'b0; req = '0;
      total++; if ({grant, busy} !== 5'b0000_1) begin bad++; $display("FAIL basic_release got=%b exp=00001", {grant, busy}); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", busy); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      do_reset();
      req = 4'b1111; m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp = 4'b0001 << (i % 4);
         tick();
         total++; if (grant !== exp) begin bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, grant, exp); end
         set_cmd(i % 4, 2'b00, 8'h00); cmd_valid = exp;
         tick();
         set_cmd(i % 4, 2'b11, 8'h00);
         tick();
         cmd_valid = '0; m_done = 1'b1;
         tick();
         m_done = 1'b0;
         total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rr_release_%0d got=%b exp=0000", i, grant); end
         tick();
         total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rr_idle_%0d got=%b exp=0000", i, grant); end
      end
   endtask

   task automatic test_proto_err();
      do_reset();
      req = 4'b0100; m_ready = 1'b1;
      tick();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL perr_grant got=%b exp=0100", grant); end
      set_cmd(2, 2'b01, 8'h3C); cmd_valid = 4'b0100;
      #1;
      total++; if ({cmd_ready, m_valid, proto_err} !== 6'b0100_0_1) begin bad++; $display("FAIL perr_drop got=%b exp=010001", {cmd_ready, m_valid, proto_err}); end
      tick();
      set_cmd(2, 2'b00, 8'h00);
      #1;
      total++; if ({m_valid, m_op, proto_err} !== 4'b1_00_0) begin bad++; $display("FAIL perr_start_fwd got=%b exp=1000", {m_valid, m_op, proto_err}); end
      tick();
      set_cmd(2, 2'b01, 8'h3C);
      #1;
      total++; if ({m_valid, m_data, proto_err} !== {1'b1, 8'h3C, 1'b0}) begin bad++; $display("FAIL perr_write_after got=%h exp=%h", {m_valid, m_data, proto_err}, {1'b1, 8'h3C, 1'b0}); end
   endtask

   task automatic test_isolation();
      do_reset();
      req = 4'b0001; m_ready = 1'b1;
      tick();
      set_cmd(0, 2'b00, 8'h12); set_cmd(1, 2'b01, 8'h77); cmd_valid = 4'b0010;
      #1;
      total++; if ({m_valid, cmd_ready[1]} !== 2'b00) begin bad++; $display("FAIL iso_other_only got=%b exp=00", {m_valid, cmd_ready[1]}); end
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      total++; if ({grant, busy} !== 5'b0001_1) begin bad++; $display("FAIL iso_done_ignored got=%b exp=00011", {grant, busy}); end
      cmd_valid = 4'b0011;
      #1;
      total++; if ({m_valid, m_op, m_data, cmd_ready} !== {1'b1, 2'b00, 8'h12, 4'b0001}) begin bad++; $display("FAIL iso_owner_fwd got=%h exp=%h", {m_valid, m_op, m_data, cmd_ready}, {1'b1, 2'b00, 8'h12, 4'b0001}); end
`ifndef I2C_ARB_TIMEOUT_EN
      cmd_valid = '0;
      repeat (30) tick();
      total++; if ({abort, grant} !== 5'b0_0001) begin bad++; $display("FAIL iso_no_timeout got=%b exp=00001", {abort, grant}); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0001; m_ready = 1'b1;
      tick();
      set_cmd(0, 2'b00, 8'h00); cmd_valid = 4'b0001;
      tick();
      set_cmd(0, 2'b11, 8'h00);
      tick();
      cmd_valid = '0; req = '0;
      total++; if ({grant, busy, m_valid} !== 6'b0001_1_0) begin bad++; $display("FAIL mid_wait got=%b exp=000110", {grant, busy, m_valid}); end
      reset_n = 1'b0;
      #1;
      total++; if ({grant, busy} !== 5'b0000_0) begin bad++; $display("FAIL mid_async_reset got=%b exp=00000", {grant, busy}); end
      tick();
      reset_n = 1'b1; req = 4'b0100;
      tick();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL mid_regrant got=%b exp=0100", grant); end
   endtask

`ifdef I2C_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      req = 4'b0001; m_ready = 1'b1;
      tick();
      set_cmd(0, 2'b00, 8'h55); cmd_valid = 4'b0001;
      tick();
      cmd_valid = '0;
      for (int c = 1; c < 10; c++) begin
         #1;
         total++; if (abort !== 1'b0) begin bad++; $display("FAIL to_early_%0d got=%b exp=0", c, abort); end
         tick();
      end
      #1;
      total++; if (abort !== 1'b1) begin bad++; $display("FAIL to_abort got=%b exp=1", abort); end
      m_ready = 1'b0;
      tick();
      total++; if ({abort, m_valid, m_op, m_data, cmd_ready} !== {1'b0, 1'b1, 2'b11, 8'h00, 4'b0000}) begin bad++; $display("FAIL to_force_stop got=%h", {abort, m_valid, m_op, m_data, cmd_ready}); end
      m_ready = 1'b1;
      tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      total++; if ({grant, m_valid} !== 5'b0000_0) begin bad++; $display("FAIL to_release got=%b exp=00000", {grant, m_valid}); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_proto_err();
      test_isolation();
      test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one I2C master byte engine (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd1000: idle-ownership limit in clk cycles; used only when I2C_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  N_REQ  per-requester bus request, level.
REQ-006 cmd_valid  in  N_REQ  per-requester command valid.
REQ-007 cmd_flat  in  10*N_REQ  per-requester {op[1:0], data[7:0]}; requester i at bits [10i+9:10i]; op 00 START, 01 WRITE, 10 READ, 11 STOP.
REQ-008 cmd_ready  out  N_REQ  per-requester command accepted.
REQ-009 grant  out  N_REQ  one-hot owner, registered; all zero when unowned.
REQ-010 m_valid / m_op / m_data  out  1 / 2 / 8  command to master engine.
REQ-011 m_ready  in  1  master engine accepts command.
REQ-012 m_done  in  1  single-cycle pulse: master finished a STOP condition.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 proto_err  out  1  single-cycle pulse on a dropped command.
REQ-015 abort  out  1  single-cycle pulse on timeout (0 without macro).

Function
REQ-016 States IDLE, OWNED, WAIT_DONE, RELEASE; plus FORCE_STOP with macro.
REQ-017 IDLE: if any req bit is high, grant is set to the winner and state goes to OWNED on the next edge (1-cycle req-to-grant latency).
REQ-018 Winner: round-robin, search starting at (last_owner+1) mod N_REQ; last_owner is N_REQ-1 after reset, so requester 0 wins first.
REQ-019 OWNED: m_valid = cmd_valid[g], {m_op,m_data} = cmd_flat slice g, cmd_ready[g] = m_ready, combinational; all other cmd_ready bits are 0.
REQ-020 First accepted command of an ownership must be START; otherwise it is consumed (cmd_ready=1, m_valid=0) and proto_err pulses.
REQ-021 STOP handshake (m_valid & m_ready & m_op==11) in OWNED moves to WAIT_DONE; m_valid and cmd_ready are 0 in WAIT_DONE.
REQ-022 WAIT_DONE: m_done moves to RELEASE; grant clears and last_owner updates on the same edge.
REQ-023 RELEASE: one dead cycle, then IDLE; no grant is issued in RELEASE even if req is high.
REQ-024 Owner deasserting req in OWNED does not release grant; only STOP completion (or timeout) does.
REQ-025 m_done outside WAIT_DONE is ignored.
REQ-026 m_valid is never asserted in IDLE, RELEASE or WAIT_DONE.

Reset
REQ-027 On reset_n low: state IDLE, grant 0, last_owner N_REQ-1, busy 0, proto_err 0, abort 0, timeout counter 0, m_valid 0, cmd_ready 0; release takes effect at the next clk edge.
REQ-028 Reset mid-transaction abandons ownership; no STOP is issued.

Configuration
REQ-029 Macro I2C_ARB_TIMEOUT_EN defined: a 16-bit counter clears on every accepted command and increments every OWNED cycle without a handshake; reaching TIMEOUT_CYCLES pulses abort and enters FORCE_STOP.
REQ-030 FORCE_STOP: m_valid=1, m_op=11, m_data=0, all cmd_ready=0; on m_ready it goes to WAIT_DONE.
REQ-031 Macro undefined: no counter and no FORCE_STOP state; abort is tied 0.

Verification
REQ-032 req=0001, then START, WRITE 8'hA5, STOP with m_ready=1 and m_done 2 cycles later -> grant=0001 1 cycle after req; m_data=A5 on WRITE; grant=0 after m_done; busy low 1 cycle later.
REQ-033 req=1111 held, each owner runs START/STOP -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-034 Owner 2 sends WRITE 8'h3C first -> cmd_ready[2]=1, m_valid=0, proto_err pulses once; a following START is forwarded.
REQ-035 Requester 1 cmd_valid while requester 0 owns -> cmd_ready[1]=0 and m_valid reflects only requester 0.
REQ-036 reset_n low during WAIT_DONE -> grant=0 and busy=0 immediately; next req=0100 -> grant=0100.
REQ-037 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, owner stalls after START -> abort pulses on the 10th idle cycle, m_op=11, then release after m_done.
